// File: rtl/sub8_approx_pkg.sv
// sub8_approx_pkg: shared definitions for the approximate 8-bit subtractor.
//   W_DEF / K_DEF / CNT_W_DEF : default operand width, approximated low bits,
//                               and error-statistics counter width.
//   result_t                  : W+1 bit {borrow_out, diff} result.
//   approx_sub / exact_sub    : reference arithmetic at the default widths.
package sub8_approx_pkg;

  localparam int unsigned W_DEF     = 8;
  localparam int unsigned K_DEF     = 3;
  localparam int unsigned CNT_W_DEF = 16;

  typedef logic [W_DEF-1:0] operand_t;
  typedef logic [W_DEF:0]   result_t;

  // Low K bits borrow-free (XOR); upper part exact with a single borrow
  // guessed from bit K-1 alone.
  function automatic result_t approx_sub(operand_t a, operand_t b);
    logic [K_DEF-1:0]     lo;
    logic                 bi;
    logic [W_DEF-K_DEF:0] hi;
    lo = a[K_DEF-1:0] ^ b[K_DEF-1:0];
    bi = ~a[K_DEF-1] & b[K_DEF-1];
    hi = {1'b0, a[W_DEF-1:K_DEF]} - {1'b0, b[W_DEF-1:K_DEF]}
         - {{(W_DEF-K_DEF){1'b0}}, bi};
    return {hi, lo};
  endfunction

  function automatic result_t exact_sub(operand_t a, operand_t b);
    return {1'b0, a} - {1'b0, b};
  endfunction

endpackage

// File: rtl/sub8_approx_pipe_if.sv
// sub8_approx_pipe_if: operand/result streaming bus.
//   in_valid/in_ready/a/b     : operand pair handshake (master -> slave).
//   out_valid/out_ready/o     : W+1 bit result handshake (slave -> master).
//   master modport : stimulus / upstream side.  slave modport : the subtractor.
interface sub8_approx_pipe_if #(
  parameter int unsigned W = sub8_approx_pkg::W_DEF
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   o;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, o
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, o
  );
endinterface

// File: rtl/sub8_err_mon.sv
// sub8_err_mon: on-line error statistics for the approximate subtractor.
//   clk, rst_n : clock, asynchronous active-low reset.
//   stat_clr   : synchronous clear; wins over a coincident transfer.
//   xfer       : a result leaves the pipeline this cycle.
//   o, e       : approximate and exact W+1 bit two's-complement results.
//   err_cnt    : number of mismatching results, saturating.
//   err_max    : largest |o - e| seen.
module sub8_err_mon #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stat_clr,
  input  logic             xfer,
  input  logic [W:0]       o,
  input  logic [W:0]       e,
  output logic [CNT_W-1:0] err_cnt,
  output logic [W:0]       err_max
);

  logic signed [W+1:0] diff;
  logic [W:0]          d;

  // One extra bit so the signed difference of two W+1 bit values cannot
  // overflow; its magnitude always fits back into W+1 bits.
  always_comb begin
    diff = $signed({o[W], o}) - $signed({e[W], e});
    d    = diff[W+1] ? (W+1)'(-diff) : (W+1)'(diff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (stat_clr) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (xfer) begin
      if (d != '0 && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      if (d > err_max)              err_max <= d;
    end
  end

endmodule

// File: rtl/sub8_approx_pipe.sv
// sub8_approx_pipe: two-stage valid/ready approximate subtractor, o = a - b.
//   Low K bits are borrow-free (a^b); upper W-K bits are exact, with the
//   borrow into them taken from bit K-1 only.
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus        : sub8_approx_pipe_if.slave (in_valid/in_ready/a/b,
//                out_valid/out_ready/o, o = {borrow_out, diff}).
//   Optional ERR_MON_EN adds stat_clr, err_cnt, err_max and the exact-result
//   path feeding sub8_err_mon.
module sub8_approx_pipe
  import sub8_approx_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned K     = K_DEF
`ifdef ERR_MON_EN
 ,parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  sub8_approx_pipe_if.slave bus
`ifdef ERR_MON_EN
 ,input  logic             stat_clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic [W:0]       err_max
`endif
);

  logic           s1_valid;
  logic           s2_valid;
  logic           s1_load;
  logic           s2_load;
  logic [W-K-1:0] s1_ah;
  logic [W-K-1:0] s1_bh;
  logic [K-1:0]   s1_lo;
  logic           s1_bi;
  logic [W-K:0]   hi;
  logic [W:0]     s2_o;

  assign s2_load       = ~s2_valid | bus.out_ready;
  assign s1_load       = ~s1_valid | s2_load;
  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid;
  assign bus.o         = s2_o;

  assign hi = {1'b0, s1_ah} - {1'b0, s1_bh} - {{(W-K){1'b0}}, s1_bi};

`ifdef ERR_MON_EN
  // Low operand bits are only needed to rebuild the exact difference.
  logic [K-1:0] s1_al;
  logic [K-1:0] s1_bl;
  logic [W:0]   s2_e;
  logic [W:0]   e_comb;

  assign e_comb = {1'b0, s1_ah, s1_al} - {1'b0, s1_bh, s1_bl};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ah    <= '0;
      s1_bh    <= '0;
      s1_lo    <= '0;
      s1_bi    <= 1'b0;
`ifdef ERR_MON_EN
      s1_al    <= '0;
      s1_bl    <= '0;
`endif
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_ah <= bus.a[W-1:K];
        s1_bh <= bus.b[W-1:K];
        s1_lo <= bus.a[K-1:0] ^ bus.b[K-1:0];
        s1_bi <= ~bus.a[K-1] & bus.b[K-1];
`ifdef ERR_MON_EN
        s1_al <= bus.a[K-1:0];
        s1_bl <= bus.b[K-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_o     <= '0;
`ifdef ERR_MON_EN
      s2_e     <= '0;
`endif
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_o <= {hi, s1_lo};
`ifdef ERR_MON_EN
        s2_e <= e_comb;
`endif
      end
    end
  end

`ifdef ERR_MON_EN
  sub8_err_mon #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_err_mon (
    .clk      (clk),
    .rst_n    (rst_n),
    .stat_clr (stat_clr),
    .xfer     (s2_valid & bus.out_ready),
    .o        (s2_o),
    .e        (s2_e),
    .err_cnt  (err_cnt),
    .err_max  (err_max)
  );
`endif

endmodule

// File: tb/tb_sub8_approx_pipe.sv
// tb_sub8_approx_pipe: self-checking bench for sub8_approx_pipe.
// Directed table vectors, latency/backpressure/reset sequences and a random
// phase, all scored against an arithmetic reference model. Build with
// +define+ERR_MON_EN to also check the error statistics.
module tb_sub8_approx_pipe;

  localparam int W     = 8;
  localparam int K     = 3;
  localparam int CNT_W = 16;
  localparam int MASK  = (1 << (W + 1)) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sub8_approx_pipe_if #(.W(W)) bus ();

`ifdef ERR_MON_EN
  logic             stat_clr;
  logic [CNT_W-1:0] err_cnt;
  logic [W:0]       err_max;
`endif

  sub8_approx_pipe #(
    .W (W),
    .K (K)
`ifdef ERR_MON_EN
   ,.CNT_W (CNT_W)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ERR_MON_EN
   ,.stat_clr (stat_clr),
    .err_cnt  (err_cnt),
    .err_max  (err_max)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic int model_approx(int a, int b);
    int lo, bi, hi;
    lo = (a ^ b) % (1 << K);
    bi = ((a / (1 << (K - 1))) % 2 == 0 && (b / (1 << (K - 1))) % 2 == 1) ? 1 : 0;
    hi = a / (1 << K) - b / (1 << K) - bi;
    return (hi * (1 << K) + lo) & MASK;
  endfunction

  function automatic int model_exact(int a, int b);
    return (a - b) & MASK;
  endfunction

  function automatic int to_signed(int v);
    return (v >= (1 << W)) ? v - (1 << (W + 1)) : v;
  endfunction

  function automatic int abs_err(int o, int e);
    int d;
    d = to_signed(o) - to_signed(e);
    return (d < 0) ? -d : d;
  endfunction

  typedef struct {
    int o;
    int d;
  } item_t;

  item_t exp_q[$];
  int    n_pop = 0;
  int    m_cnt = 0;
  int    m_max = 0;
  logic  stall_prev = 1'b0;
  int    prev_o = 0;

  // Scoreboard, sampled on the falling edge: inputs are driven just after the
  // rising edge, so the values seen here are what the next rising edge uses.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0;
      m_max = 0;
      stall_prev = 1'b0;
    end else begin
      item_t r;
      if (stall_prev) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_o", int'(bus.o), prev_o);
      end
`ifdef ERR_MON_EN
      chk("err_cnt", int'(err_cnt), m_cnt);
      chk("err_max", int'(err_max), m_max);
`endif
      chk("in_ready", int'(bus.in_ready),
          (exp_q.size() < 2 || bus.out_ready) ? 1 : 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_spurious", int'(bus.out_valid), 0);
        end else begin
          r = exp_q.pop_front();
          chk("sb_o", int'(bus.o), r.o);
          n_pop++;
`ifdef ERR_MON_EN
          if (!stat_clr) begin
            if (r.d != 0 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (r.d > m_max) m_max = r.d;
          end
`endif
        end
      end
`ifdef ERR_MON_EN
      if (stat_clr) begin
        m_cnt = 0;
        m_max = 0;
      end
`endif
      if (bus.in_valid && bus.in_ready) begin
        r.o = model_approx(int'(bus.a), int'(bus.b));
        r.d = abs_err(r.o, model_exact(int'(bus.a), int'(bus.b)));
        exp_q.push_back(r);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_o = int'(bus.o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] o;
    int         cnt;
    int         mx;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int pop0;
    int vi;

    tbl[0] = '{8'h50, 8'h23, 9'h033, 1, 6};
    tbl[1] = '{8'h10, 8'h20, 9'h1F0, 1, 6};
    tbl[2] = '{8'h04, 8'h07, 9'h003, 2, 6};
    tbl[3] = '{8'hFF, 8'h00, 9'h0FF, 2, 6};
    tbl[4] = '{8'h00, 8'hFF, 9'h107, 3, 6};
    tbl[5] = '{8'h08, 8'h01, 9'h009, 4, 6};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
`ifdef ERR_MON_EN
    stat_clr      = 1'b0;
`endif

    // Reset state
    step();
    step();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_o", int'(bus.o), 0);
`ifdef ERR_MON_EN
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_err_max", int'(err_max), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);
    chk("post_rst_out_valid", int'(bus.out_valid), 0);
    step();

    // Directed table: one pair at a time, 2-cycle latency, cumulative stats
    for (int i = 0; i < 6; i++) begin
      bus.a = tbl[i].a;
      bus.b = tbl[i].b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("tbl_lat1_valid", int'(bus.out_valid), 0);
      step();
      @(negedge clk);
      chk("tbl_lat2_valid", int'(bus.out_valid), 1);
      chk("tbl_o", int'(bus.o), int'(tbl[i].o));
      step();
`ifdef ERR_MON_EN
      @(negedge clk);
      chk("tbl_err_cnt", int'(err_cnt), tbl[i].cnt);
      chk("tbl_err_max", int'(err_max), tbl[i].mx);
`endif
      step();
    end

    // Back-to-back stream of 4 pairs with out_ready held high
    bus.out_ready = 1'b1;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) begin
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      chk("stream_in_ready", int'(bus.in_ready), 1);
      chk("stream_out_valid", int'(bus.out_valid), (i >= 1) ? 1 : 0);
    end
    step();
    @(negedge clk);
    chk("stream_last_valid", int'(bus.out_valid), 1);
    step();
    @(negedge clk);
    chk("stream_done_valid", int'(bus.out_valid), 0);

    // Fill with out_ready low, then release
    step();
    pop0 = n_pop;
    bus.out_ready = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    bus.in_valid = 1'b1;
    step();
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    @(negedge clk);
    chk("fill_in_ready_1", int'(bus.in_ready), 1);
    step();
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    @(negedge clk);
    chk("fill_in_ready_full", int'(bus.in_ready), 0);
    step();
    @(negedge clk);
    chk("fill_held_in_ready", int'(bus.in_ready), 0);
    chk("fill_held_valid", int'(bus.out_valid), 1);
    step();
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("fill_drained", exp_q.size(), 0);
    chk("fill_count", n_pop - pop0, 3);

    // Reset with two results in flight
    bus.out_ready = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    bus.in_valid = 1'b1;
    step();
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    step();
    bus.in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
`ifdef ERR_MON_EN
    chk("midrst_err_cnt", int'(err_cnt), 0);
`endif
    step();
    rst_n = 1'b1;
    step();
    bus.a = 8'h50;
    bus.b = 8'h23;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_lat1_valid", int'(bus.out_valid), 0);
    step();
    @(negedge clk);
    chk("midrst_lat2_valid", int'(bus.out_valid), 1);
    chk("midrst_o", int'(bus.o), model_approx(8'h50, 8'h23));
    step();

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
`ifdef ERR_MON_EN
      stat_clr      = ($urandom_range(0, 19) == 0);
`endif
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
`ifdef ERR_MON_EN
    stat_clr      = 1'b0;
`endif
    vi = 0;
    while (vi < 20 && exp_q.size() != 0) begin
      step();
      vi++;
    end
    chk("rand_drained", exp_q.size(), 0);
    step();
    @(negedge clk);
    chk("final_out_valid", int'(bus.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
